fir_param_pipe: RTL and testbench

FIR_PARAM_PIPE -- requirements
Module: fir_param_pipe

---
 rtl/fir_param_pipe.sv | 152 +++++++++++++++
 tb/tb_fir_param_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param_pipe.sv
// Parameterised direct-form FIR with runtime-writable coefficients.
// Three register stages: split partial sums, their total, then round/shift/saturate.
module fir_param_pipe #(
    parameter int DATA_W = 10,
    parameter int COEF_W = 6,
    parameter int TAPS   = 21,
    parameter int OUT_W  = 12,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] filter_in,
    input  logic              coef_wr,
    input  logic [5:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  filter_out,
    output logic              sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int HALF   = TAPS / 2;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Rounding constant is 0.5 LSB of the shifted result, absent when no shift is applied
    localparam logic [ACC_W:0] RND_V = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W:0] MAX_V =
        $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] MIN_V =
        $signed({{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}});

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] dly_q  [TAPS-1];
    logic signed [DATA_W-1:0] tap_x  [TAPS];

    logic signed [ACC_W-1:0] sum_lo, sum_hi;
    logic signed [ACC_W-1:0] lo_q, hi_q, tot_q;
    logic                    v1_q, v2_q;

    logic signed [ACC_W:0]   rnd_sum, shifted;
    logic [OUT_W-1:0]        clip_val;
    logic                    clip_hit;

    // Tap 0 is the incoming sample itself; the delay line supplies the older ones
    always_comb begin
        tap_x[0] = $signed(filter_in);
        for (int k = 1; k < TAPS; k++) begin
            tap_x[k] = dly_q[k-1];
        end
    end

    // Full-precision products summed into the lower and upper halves of the tap set
    always_comb begin
        logic signed [PROD_W-1:0] xe, ce, prod;
        logic signed [ACC_W-1:0]  pe;
        sum_lo = '0;
        sum_hi = '0;
        xe     = '0;
        ce     = '0;
        prod   = '0;
        pe     = '0;
        for (int k = 0; k < TAPS; k++) begin
            xe   = {{COEF_W{tap_x[k][DATA_W-1]}}, tap_x[k]};
            ce   = {{DATA_W{coef_q[k][COEF_W-1]}}, coef_q[k]};
            prod = xe * ce;
            pe   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
            if (k < HALF) begin
                sum_lo = sum_lo + pe;
            end else begin
                sum_hi = sum_hi + pe;
            end
        end
    end

    // Coefficient writes and delay-line shift; a write lands after this edge's sample uses the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
            for (int k = 0; k < TAPS - 1; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_wr && (32'(coef_addr) == k)) begin
                    coef_q[k] <= $signed(coef_data);
                end
            end
            if (in_valid) begin
                dly_q[0] <= $signed(filter_in);
                for (int k = 1; k < TAPS - 1; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end
    end

    // Stages 1 and 2: register partial sums, then their total
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q  <= '0;
            hi_q  <= '0;
            v1_q  <= 1'b0;
            tot_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                lo_q <= sum_lo;
                hi_q <= sum_hi;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                tot_q <= lo_q + hi_q;
            end
        end
    end

    // Round half up, arithmetic shift, clip to the output range
    always_comb begin
        rnd_sum  = {tot_q[ACC_W-1], tot_q} + $signed(RND_V);
        shifted  = rnd_sum >>> SHIFT;
        clip_hit = 1'b0;
        clip_val = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            clip_val = MAX_V[OUT_W-1:0];
            clip_hit = 1'b1;
        end else if (shifted < MIN_V) begin
            clip_val = MIN_V[OUT_W-1:0];
            clip_hit = 1'b1;
        end
    end

    // Stage 3: output register, held between valid samples
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            filter_out <= '0;
            sat        <= 1'b0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                filter_out <= clip_val;
                sat        <= clip_hit;
            end
        end
    end

endmodule

// File: tb/tb_fir_param_pipe.sv
// Directed bench for fir_param_pipe: impulse, saturation, rounding, coefficient timing, reset.
module tb_fir_param_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [9:0]  filter_in = '0;
    logic        coef_wr = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [5:0]  coef_data = '0;
    logic        out_valid, sat;
    logic [11:0] filter_out;
    logic        out_valid_s1, sat_s1;
    logic [11:0] filter_out_s1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int oq_val[$];
    int oq_sat[$];
    int oq_cyc[$];
    int in_cyc[$];
    int s1_val[$];
    int last_out = 0;
    int last_sat = 0;

    int c29[21] = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, 21, 18, 10, 1, -4, -4, -1, 2, 3, 1, -1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_param_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .filter_in  (filter_in),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .filter_out (filter_out),
        .sat        (sat)
    );

    fir_param_pipe #(.SHIFT(1)) dut_s1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .filter_in  (filter_in),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .out_valid  (out_valid_s1),
        .filter_out (filter_out_s1),
        .sat        (sat_s1)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clip12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Collect outputs; between valid pulses the output must not move
    always @(negedge clk) begin
        if (rst) begin
            last_out = 0;
            last_sat = 0;
        end else if (out_valid) begin
            oq_val.push_back(int'($signed(filter_out)));
            oq_sat.push_back(int'(sat));
            oq_cyc.push_back(cyc);
            last_out = int'($signed(filter_out));
            last_sat = int'(sat);
        end else begin
            check_val("hold_out", $signed(filter_out), last_out);
            check_val("hold_sat", sat, last_sat);
        end
        if (!rst && out_valid_s1) s1_val.push_back(int'($signed(filter_out_s1)));
    end

    task automatic clear_q();
        oq_val.delete();
        oq_sat.delete();
        oq_cyc.delete();
        in_cyc.delete();
        s1_val.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        coef_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            coef_wr = 1'b0;
        end
    endtask

    task automatic push(input int x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        coef_wr = 1'b0;
        filter_in = 10'(x);
        in_cyc.push_back(cyc);
    endtask

    task automatic wr_coef(input int a, input int d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_wr = 1'b1;
        coef_addr = 6'(a);
        coef_data = 6'(d);
    endtask

    task automatic load_c29();
        for (int k = 0; k < 21; k++) wr_coef(k, c29[k]);
        idle(1);
    endtask

    // Fixed drain window: covers the 3-cycle latency with margin, so extras would show too
    task automatic drain(input int n);
        idle(6);
        check_val("out_count", oq_val.size(), n);
    endtask

    task automatic check_impulse(input string tag);
        for (int i = 0; i < 21; i++) begin
            if (i < oq_val.size()) begin
                // c[10]*100 = 2100 exceeds the 12-bit range and clips
                check_val({tag, "_val"}, oq_val[i], clip12(100 * c29[i]));
                check_val({tag, "_sat"}, oq_sat[i], (100 * c29[i] > 2047) ? 1 : 0);
                check_val({tag, "_lat"}, oq_cyc[i] - in_cyc[i], 3);
            end
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_out", $signed(filter_out), 0);
        check_val("rst_sat", sat, 0);

        // Impulse, back-to-back samples
        load_c29();
        clear_q();
        push(100);
        for (int i = 0; i < 20; i++) push(0);
        drain(21);
        check_impulse("imp");

        // Impulse with random gaps between samples
        clear_q();
        for (int i = 0; i < 21; i++) begin
            push((i == 0) ? 100 : 0);
            idle($urandom_range(0, 3));
        end
        drain(21);
        check_val("gap_count", oq_val.size(), in_cyc.size());
        check_impulse("gap");

        // Saturation at both rails
        for (int k = 0; k < 21; k++) wr_coef(k, 31);
        idle(1);
        clear_q();
        for (int i = 0; i < 21; i++) push(511);
        drain(21);
        if (oq_val.size() == 21) begin
            check_val("satp_val", oq_val[20], 2047);
            check_val("satp_sat", oq_sat[20], 1);
        end
        clear_q();
        for (int i = 0; i < 21; i++) push(-512);
        drain(21);
        if (oq_val.size() == 21) begin
            check_val("satn_val", oq_val[20], -2048);
            check_val("satn_sat", oq_sat[20], 1);
        end

        // Rounding with SHIFT=1: (3+1)>>1=2, (-3+1)>>1=-1, (1+1)>>1=1
        do_reset();
        wr_coef(0, 1);
        idle(1);
        clear_q();
        push(3);
        push(-3);
        push(1);
        drain(3);
        check_val("s1_count", s1_val.size(), 3);
        if (s1_val.size() == 3) begin
            check_val("s1_a", s1_val[0], 2);
            check_val("s1_b", s1_val[1], -1);
            check_val("s1_c", s1_val[2], 1);
        end
        if (oq_val.size() == 3) begin
            check_val("s0_a", oq_val[0], 3);
            check_val("s0_b", oq_val[1], -3);
            check_val("s0_c", oq_val[2], 1);
        end

        // Coefficient write coinciding with a sample, then an out-of-range write
        do_reset();
        wr_coef(0, 1);
        idle(1);
        clear_q();
        @(posedge clk); #1;
        in_valid = 1'b1;
        filter_in = 10'd7;
        coef_wr = 1'b1;
        coef_addr = 6'd0;
        coef_data = 6'd5;
        in_cyc.push_back(cyc);
        push(7);
        wr_coef(21, 9);
        push(7);
        drain(3);
        if (oq_val.size() == 3) begin
            check_val("cw_old", oq_val[0], 7);
            check_val("cw_new", oq_val[1], 35);
            check_val("cw_oob", oq_val[2], 35);
        end

        // Reset with two samples in flight; writes and samples during reset are ignored
        do_reset();
        load_c29();
        clear_q();
        push(100);
        push(0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        filter_in = 10'd55;
        coef_wr = 1'b1;
        coef_addr = 6'd0;
        coef_data = 6'd7;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_valid", out_valid, 0);
        check_val("mid_out", $signed(filter_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        coef_wr = 1'b0;
        idle(6);
        check_val("stale", oq_val.size(), 0);
        clear_q();
        push(100);
        for (int i = 0; i < 20; i++) push(0);
        drain(21);
        for (int i = 0; i < 21; i++) begin
            if (i < oq_val.size()) check_val("coef_clr", oq_val[i], 0);
        end
        load_c29();
        clear_q();
        push(100);
        for (int i = 0; i < 20; i++) push(0);
        drain(21);
        check_impulse("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
